// File: rtl/hex_xmt_if.sv
// Byte handshake between the hex formatter and the serial transmitter buffer.
interface hex_xmt_if;
  logic       xmt_write;
  logic       xmt_ready;
  logic [7:0] xmt_data;

  modport master (output xmt_write, output xmt_data, input xmt_ready);
  modport slave  (input xmt_write, input xmt_data, output xmt_ready);
endinterface

// File: rtl/hex_xmt.sv
// Formats a latched 32-bit word as 1..8 ASCII hex digits (MS nibble first),
// optionally followed by CR LF, one byte per write/ready handshake.
//
// state | meaning
// IDLE  | waiting for start
// WAIT  | current character pending, waiting for xmt_ready
// GAP   | one cycle after a strobe while the buffer's ready catches up
// DONE  | done pulse, then back to IDLE
module hex_xmt #(
  parameter bit UPPER = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] value,
  input  logic [2:0]  ndigits,
  input  logic        crlf,
  output logic        busy,
  output logic        done,
  hex_xmt_if.master   xmt
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_GAP, S_DONE} state_t;
  typedef enum logic [1:0] {P_DIGITS, P_CR, P_LF} phase_t;

  state_t      state, state_n;
  phase_t      phase;
  logic [31:0] value_q;
  logic [3:0]  cnt;
  logic        crlf_q;

  logic        busy_n, done_n, write_n;
  logic [7:0]  data_n;
  logic [3:0]  nib;
  logic [7:0]  char_c;
  logic        last;

  // Datapath: operands latch only on an accepted start and advance in GAP.
  always_ff @(posedge clk) begin
    if (reset) begin
      value_q <= '0;
      cnt     <= '0;
      crlf_q  <= 1'b0;
      phase   <= P_DIGITS;
    end else if (state == S_IDLE && start) begin
      value_q <= value;
      crlf_q  <= crlf;
      phase   <= P_DIGITS;
      cnt     <= (ndigits == 3'd0) ? 4'd8 : {1'b0, ndigits};
    end else if (state == S_GAP) begin
      case (phase)
        P_DIGITS: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1 && crlf_q) phase <= P_CR;
        end
        P_CR:    phase <= P_LF;
        default: phase <= phase;
      endcase
    end
  end

  always_comb begin
    case (cnt)
      4'd8:    nib = value_q[31:28];
      4'd7:    nib = value_q[27:24];
      4'd6:    nib = value_q[23:20];
      4'd5:    nib = value_q[19:16];
      4'd4:    nib = value_q[15:12];
      4'd3:    nib = value_q[11:8];
      4'd2:    nib = value_q[7:4];
      default: nib = value_q[3:0];
    endcase
  end

  always_comb begin
    char_c = 8'h00;
    case (phase)
      P_DIGITS: begin
        if (nib < 4'd10) char_c = {4'h3, nib};
        else             char_c = (UPPER ? 8'h41 : 8'h61) + {4'h0, nib} - 8'd10;
      end
      P_CR:    char_c = 8'h0D;
      P_LF:    char_c = 8'h0A;
      default: char_c = 8'h00;
    endcase
  end

  assign last = (phase == P_DIGITS && cnt == 4'd1 && !crlf_q) || (phase == P_LF);

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      xmt.xmt_write <= 1'b0;
      xmt.xmt_data  <= 8'h00;
    end else begin
      state         <= state_n;
      busy          <= busy_n;
      done          <= done_n;
      xmt.xmt_write <= write_n;
      xmt.xmt_data  <= data_n;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (start) state_n = S_WAIT;
      S_WAIT:  if (xmt.xmt_ready) state_n = S_GAP;
      S_GAP:   state_n = last ? S_DONE : S_WAIT;
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Outputs are registered; done is high for the whole DONE cycle.
  always_comb begin
    busy_n  = busy;
    done_n  = 1'b0;
    write_n = 1'b0;
    data_n  = xmt.xmt_data;
    case (state)
      S_IDLE: if (start) busy_n = 1'b1;
      S_WAIT: if (xmt.xmt_ready) begin
        write_n = 1'b1;
        data_n  = char_c;
      end
      S_GAP:  if (last) done_n = 1'b1;
      S_DONE: busy_n = 1'b0;
      default: busy_n = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_hex_xmt.sv
// Directed bench for hex_xmt: uppercase and lowercase instances, forced ready
// and a small buffer model whose ready drops after each strobe.
module tb_hex_xmt;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        start_up = 1'b0, start_lo = 1'b0;
  logic [31:0] value = '0;
  logic [2:0]  ndigits = '0;
  logic        crlf = 1'b0;
  logic        busy_up, done_up, busy_lo, done_lo;

  hex_xmt_if bus_up();
  hex_xmt_if bus_lo();

  hex_xmt #(.UPPER(1'b1)) u_up (
    .clk(clk), .reset(reset), .start(start_up), .value(value), .ndigits(ndigits),
    .crlf(crlf), .busy(busy_up), .done(done_up), .xmt(bus_up.master)
  );

  hex_xmt #(.UPPER(1'b0)) u_lo (
    .clk(clk), .reset(reset), .start(start_lo), .value(value), .ndigits(ndigits),
    .crlf(crlf), .busy(busy_lo), .done(done_lo), .xmt(bus_lo.master)
  );

  int checks = 0;
  int failures = 0;

  // Buffer model: ready drops the cycle after a strobe, returns buf_gap cycles later.
  logic force_en = 1'b1, force_val = 1'b1;
  logic buf_ready = 1'b1;
  int   buf_gap = 0, buf_cnt = 0;
  always @(posedge clk) begin
    if (bus_up.xmt_write) begin
      buf_ready <= 1'b0;
      buf_cnt   <= buf_gap;
    end else if (buf_cnt > 0) buf_cnt <= buf_cnt - 1;
    else buf_ready <= 1'b1;
  end
  assign bus_up.xmt_ready = force_en ? force_val : buf_ready;
  assign bus_lo.xmt_ready = 1'b1;

  logic [7:0] got_up[$];
  logic [7:0] got_lo[$];
  int   viol_up = 0, done_cnt_up = 0, done_cnt_lo = 0;
  logic rdy_q_up = 1'b0, prev_wr_up = 1'b0;
  logic [7:0] last_data_up = 8'h00;

  always @(posedge clk) rdy_q_up <= bus_up.xmt_ready;

  always @(posedge clk) begin
    #1;
    if (bus_up.xmt_write) begin
      got_up.push_back(bus_up.xmt_data);
      if (prev_wr_up) viol_up++;
      if (!rdy_q_up) viol_up++;
      last_data_up = bus_up.xmt_data;
    end else if (reset) begin
      last_data_up = bus_up.xmt_data;
    end else if (bus_up.xmt_data !== last_data_up) begin
      viol_up++;
    end
    prev_wr_up = bus_up.xmt_write;
    if (done_up) done_cnt_up++;
    if (bus_lo.xmt_write) got_lo.push_back(bus_lo.xmt_data);
    if (done_lo) done_cnt_lo++;
  end

  task automatic do_start(input bit lo, input logic [31:0] v, input logic [2:0] nd, input bit c);
    @(negedge clk);
    value = v; ndigits = nd; crlf = c;
    if (lo) start_lo = 1'b1; else start_up = 1'b1;
    @(negedge clk);
    start_lo = 1'b0; start_up = 1'b0;
    value = $urandom; ndigits = 3'($urandom); crlf = 1'($urandom);
  endtask

  task automatic wait_done(input bit lo, input int budget, output int cycles, output bit seen);
    cycles = 0;
    seen = lo ? done_lo : done_up;
    while (!seen && cycles < budget) begin
      @(negedge clk);
      cycles++;
      seen = lo ? done_lo : done_up;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (busy_up !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy_up); end
    checks++; if (done_up !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done_up); end
    checks++; if (bus_up.xmt_write !== 1'b0) begin failures++; $display("FAIL reset_write got=%b exp=0", bus_up.xmt_write); end
    checks++; if (bus_up.xmt_data !== 8'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", bus_up.xmt_data); end
    checks++; if (busy_lo !== 1'b0) begin failures++; $display("FAIL reset_busy_lo got=%b exp=0", busy_lo); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_full_word();
    logic [7:0] exp [10] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h41, 8'h42, 8'h43, 8'h44, 8'h0D, 8'h0A};
    int cyc; bit seen; int d0;
    force_en = 1'b1; force_val = 1'b1;
    got_up.delete(); viol_up = 0; d0 = done_cnt_up;
    do_start(1'b0, 32'h1234ABCD, 3'd0, 1'b1);
    wait_done(1'b0, 200, cyc, seen);
    checks++; if (!seen) begin failures++; $display("FAIL full_timeout got=no_done exp=done"); end
    checks++; if (cyc !== 20) begin failures++; $display("FAIL full_latency got=%0d exp=20", cyc); end
    @(negedge clk);
    checks++; if (busy_up !== 1'b0 || done_up !== 1'b0) begin failures++; $display("FAIL full_after got=busy%b/done%b exp=0/0", busy_up, done_up); end
    checks++; if (got_up.size() !== 10) begin failures++; $display("FAIL full_count got=%0d exp=10", got_up.size()); end
    for (int i = 0; i < 10 && i < got_up.size(); i++) begin
      checks++; if (got_up[i] !== exp[i]) begin failures++; $display("FAIL full_char%0d got=%h exp=%h", i, got_up[i], exp[i]); end
    end
    checks++; if (done_cnt_up - d0 !== 1) begin failures++; $display("FAIL full_done_pulses got=%0d exp=1", done_cnt_up - d0); end
    checks++; if (viol_up !== 0) begin failures++; $display("FAIL full_handshake got=%0d exp=0", viol_up); end
  endtask

  task automatic test_lowercase();
    int cyc; bit seen;
    got_lo.delete();
    do_start(1'b1, 32'h000000FF, 3'd2, 1'b0);
    wait_done(1'b1, 100, cyc, seen);
    checks++; if (!seen) begin failures++; $display("FAIL lower_timeout got=no_done exp=done"); end
    checks++; if (cyc !== 4) begin failures++; $display("FAIL lower_latency got=%0d exp=4", cyc); end
    repeat (5) @(negedge clk);
    checks++; if (got_lo.size() !== 2) begin failures++; $display("FAIL lower_count got=%0d exp=2", got_lo.size()); end
    for (int i = 0; i < 2 && i < got_lo.size(); i++) begin
      checks++; if (got_lo[i] !== 8'h66) begin failures++; $display("FAIL lower_char%0d got=%h exp=66", i, got_lo[i]); end
    end
  endtask

  task automatic test_backpressure();
    int bad; int cyc; bit seen;
    got_up.delete(); bad = 0;
    force_en = 1'b1; force_val = 1'b0;
    do_start(1'b0, 32'h0, 3'd1, 1'b0);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus_up.xmt_write !== 1'b0 || busy_up !== 1'b1) bad++;
    end
    checks++; if (bad !== 0) begin failures++; $display("FAIL bp_hold got=%0d_bad_cycles exp=0", bad); end
    force_val = 1'b1;
    @(posedge clk); #1;
    checks++; if (bus_up.xmt_write !== 1'b1 || bus_up.xmt_data !== 8'h30) begin
      failures++; $display("FAIL bp_release got=wr%b/%h exp=1/30", bus_up.xmt_write, bus_up.xmt_data);
    end
    wait_done(1'b0, 50, cyc, seen);
    checks++; if (!seen || got_up.size() !== 1) begin failures++; $display("FAIL bp_done got=seen%0d/n%0d exp=1/1", seen, got_up.size()); end
    @(negedge clk);
  endtask

  task automatic test_start_while_busy();
    logic [7:0] exp [3] = '{8'h35, 8'h0D, 8'h0A};
    int cyc; bit seen;
    got_up.delete();
    force_en = 1'b1; force_val = 1'b1;
    do_start(1'b0, 32'h00000005, 3'd1, 1'b1);
    value = 32'hFFFFFFFF; ndigits = 3'd0; crlf = 1'b0; start_up = 1'b1;
    @(negedge clk);
    start_up = 1'b0;
    wait_done(1'b0, 100, cyc, seen);
    checks++; if (!seen) begin failures++; $display("FAIL busy_start_timeout got=no_done exp=done"); end
    repeat (30) @(negedge clk);
    checks++; if (got_up.size() !== 3) begin failures++; $display("FAIL busy_start_count got=%0d exp=3", got_up.size()); end
    for (int i = 0; i < 3 && i < got_up.size(); i++) begin
      checks++; if (got_up[i] !== exp[i]) begin failures++; $display("FAIL busy_start_char%0d got=%h exp=%h", i, got_up[i], exp[i]); end
    end
    checks++; if (busy_up !== 1'b0) begin failures++; $display("FAIL busy_start_queued got=%b exp=0", busy_up); end
  endtask

  task automatic test_back_to_back();
    int cyc; bit seen;
    got_up.delete();
    force_en = 1'b1; force_val = 1'b1;
    @(negedge clk);
    value = 32'h00000007; ndigits = 3'd1; crlf = 1'b0; start_up = 1'b1;
    wait_done(1'b0, 50, cyc, seen);
    checks++; if (!seen) begin failures++; $display("FAIL b2b_timeout got=no_done exp=done"); end
    @(negedge clk);
    checks++; if (busy_up !== 1'b0) begin failures++; $display("FAIL b2b_idle_gap got=%b exp=0", busy_up); end
    @(negedge clk);
    checks++; if (busy_up !== 1'b1) begin failures++; $display("FAIL b2b_restart got=%b exp=1", busy_up); end
    start_up = 1'b0;
    wait_done(1'b0, 50, cyc, seen);
    checks++; if (got_up.size() !== 2 || got_up[0] !== 8'h37) begin failures++; $display("FAIL b2b_chars got=n%0d exp=n2", got_up.size()); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic [7:0] exp [10] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h41, 8'h42, 8'h43, 8'h44, 8'h0D, 8'h0A};
    int cyc; bit seen; int d0; int guard;
    got_up.delete();
    force_en = 1'b1; force_val = 1'b1;
    do_start(1'b0, 32'h1234ABCD, 3'd0, 1'b1);
    guard = 0;
    while (got_up.size() < 3 && guard < 100) begin @(negedge clk); guard++; end
    checks++; if (got_up.size() !== 3) begin failures++; $display("FAIL rmid_reach got=%0d exp=3", got_up.size()); end
    reset = 1'b1;
    @(posedge clk); #1;
    checks++; if (busy_up !== 1'b0 || done_up !== 1'b0 || bus_up.xmt_write !== 1'b0) begin
      failures++; $display("FAIL rmid_abort got=b%b/d%b/w%b exp=0/0/0", busy_up, done_up, bus_up.xmt_write);
    end
    @(negedge clk);
    reset = 1'b0;
    d0 = done_cnt_up;
    repeat (30) @(negedge clk);
    checks++; if (got_up.size() !== 3 || done_cnt_up !== d0) begin
      failures++; $display("FAIL rmid_quiet got=n%0d/done%0d exp=n3/done0", got_up.size(), done_cnt_up - d0);
    end
    got_up.delete(); viol_up = 0;
    do_start(1'b0, 32'h1234ABCD, 3'd0, 1'b1);
    wait_done(1'b0, 200, cyc, seen);
    checks++; if (!seen || got_up.size() !== 10) begin failures++; $display("FAIL rmid_restart got=seen%0d/n%0d exp=1/10", seen, got_up.size()); end
    for (int i = 0; i < 10 && i < got_up.size(); i++) begin
      checks++; if (got_up[i] !== exp[i]) begin failures++; $display("FAIL rmid_char%0d got=%h exp=%h", i, got_up[i], exp[i]); end
    end
    @(negedge clk);
  endtask

  task automatic test_buffer_model();
    logic [7:0] exp [10] = '{8'h44, 8'h45, 8'h41, 8'h44, 8'h42, 8'h45, 8'h45, 8'h46, 8'h0D, 8'h0A};
    logic [7:0] exp2 [3] = '{8'h45, 8'h39, 8'h46};
    int cyc; bit seen;
    got_up.delete(); viol_up = 0;
    force_en = 1'b0; buf_gap = 5;
    do_start(1'b0, 32'hDEADBEEF, 3'd0, 1'b1);
    wait_done(1'b0, 500, cyc, seen);
    checks++; if (!seen || got_up.size() !== 10) begin failures++; $display("FAIL line_count got=seen%0d/n%0d exp=1/10", seen, got_up.size()); end
    for (int i = 0; i < 10 && i < got_up.size(); i++) begin
      checks++; if (got_up[i] !== exp[i]) begin failures++; $display("FAIL line_char%0d got=%h exp=%h", i, got_up[i], exp[i]); end
    end
    got_up.delete(); buf_gap = 2;
    do_start(1'b0, 32'h00000E9F, 3'd3, 1'b0);
    wait_done(1'b0, 200, cyc, seen);
    checks++; if (!seen || got_up.size() !== 3) begin failures++; $display("FAIL mixed_count got=seen%0d/n%0d exp=1/3", seen, got_up.size()); end
    for (int i = 0; i < 3 && i < got_up.size(); i++) begin
      checks++; if (got_up[i] !== exp2[i]) begin failures++; $display("FAIL mixed_char%0d got=%h exp=%h", i, got_up[i], exp2[i]); end
    end
    checks++; if (viol_up !== 0) begin failures++; $display("FAIL line_handshake got=%0d exp=0", viol_up); end
    force_en = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_full_word();
    test_lowercase();
    test_backpressure();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid();
    test_buffer_model();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hex_xmt.md
Name: hex_xmt

Overview:
Upstream feeder for the serial transmitter buffer in the flash programmer. It takes a latched 32-bit value and converts 1..8 nibbles, most significant first, to ASCII hex characters. It can append CR LF. Characters are handed one at a time to the buffer over its write/ready handshake. It is used to report addresses, data words and checksums back to the host.

Parameters:
UPPER, 1, 1 = hex letters 'A'-'F' (0x41-0x46); 0 = 'a'-'f' (0x61-0x66)

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
start  in  1  request to emit; sampled only in IDLE
value  in  32  word to print; latched on accepted start
ndigits  in  3  number of nibbles to print, 1..7; 0 means 8; latched on start
crlf  in  1  1 = append 0x0D 0x0A after the digits; latched on start
busy  out  1  high from the cycle after an accepted start until done
done  out  1  single-cycle pulse after the last character is handed off
xmt_write  out  1  single-cycle write strobe to the transmitter buffer
xmt_ready  in  1  transmitter buffer can accept a byte
xmt_data  out  8  character; valid while xmt_write is high

Behaviour:
- Clock and reset: clk is the clock; reset is synchronous, active-high.
- Reset values: busy=0, done=0, xmt_write=0, xmt_data=0x00, state=IDLE. Reset mid-sequence aborts at once with no further writes and no done pulse. A byte already strobed into the buffer is left to the buffer.
- Registered state: value_q[31:0], cnt[3:0] (digits remaining), crlf_q, phase (DIGITS, CR, LF).
- State IDLE:
  - start=1 → latch value, crlf and cnt (ndigits, with 0 mapped to 8); busy<=1; go to WAIT.
  - start=0 → stay.
- State WAIT:
  - xmt_ready=1 → xmt_write<=1 and xmt_data<=current char; go to GAP.
  - xmt_ready=0 → hold with no write. There is no timeout; it waits indefinitely.
- Current char by phase:
  - DIGITS: nibble n = value_q[4*cnt-1 -: 4]. n<10 gives 0x30+n. n>=10 gives 0x41+n-10 (UPPER=1) or 0x61+n-10 (UPPER=0).
  - CR: 0x0D.
  - LF: 0x0A.
- State GAP: exactly one cycle.
  - xmt_write<=0, because the buffer's ready is registered and does not fall until the cycle after the strobe.
  - Advance: in DIGITS, cnt<=cnt-1. When cnt reaches 0, move to CR if crlf_q, otherwise finish. CR moves to LF. LF finishes.
  - Not finished → WAIT.
  - Finished → DONE.
- State DONE: done<=1 for one cycle, busy<=0; return to IDLE.
  - start is not accepted in DONE.
  - The earliest new start is accepted on the cycle after done.
- Handshake invariants:
  - xmt_write is never high on two consecutive cycles.
  - xmt_write is high only on a cycle following one where xmt_ready was sampled 1.
  - xmt_data is stable from the write cycle until the next write.
- start while busy is ignored, with no effect on latched operands.
- Operands may change freely after the accepted start.
- Total writes per request = digits + 2*crlf, in the range 1..10.
- Minimum latency with xmt_ready held 1: 2 cycles per character, plus 1 start cycle and 1 DONE cycle.

Test Plan:
- Full word: value=0x1234ABCD, ndigits=0, crlf=1, xmt_ready=1 → writes 0x31 0x32 0x33 0x34 0x41 0x42 0x43 0x44 0x0D 0x0A, each strobe 1 cycle with ≥1 idle cycle between; done pulses once; busy low after.
- Short field, lowercase: UPPER=0, value=0x000000FF, ndigits=2, crlf=0 → exactly two writes, 0x66 0x66; done; no CR/LF.
- Backpressure: hold xmt_ready=0 for 50 cycles after start → xmt_write stays 0 and busy stays 1. Release → first char 0x30 for value=0x0, ndigits=1, crlf=0 is written within 1 cycle.
- Start while busy: second start with value=0xFFFFFFFF during the first request (value=0x00000005, ndigits=1, crlf=1) → output 0x35 0x0D 0x0A only; second request not queued.
- Reset mid-operation: assert reset after the 3rd write of the 0x1234ABCD case → next cycle busy=0, done=0, xmt_write=0; no further writes. A new start then prints a full sequence correctly.
- Integration with the transmitter buffer and serial line model at 115200 baud: 0xDEADBEEF with CR LF decodes on the line as "DEADBEEF\r\n", with no dropped or duplicated characters.
